// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encodings,
// PC/writeback select codes and the decoded instruction-class bundle.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2
    } pcsel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_UIMM = 2'd3
    } wbsel_t;

    typedef struct packed {
        logic alureg;
        logic aluimm;
        logic branch;
        logic jalr;
        logic jal;
        logic auipc;
        logic lui;
        logic load;
        logic store;
        logic system;
    } iclass_t;

    localparam int unsigned TIMER_W = 8;

    function automatic logic is_onehot(input iclass_t c);
        logic [9:0]  bits;
        int unsigned n;
        bits = c;
        n    = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            n = n + {31'b0, bits[i]};
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Decoder/memory handshake bundle between the control sequencer (master)
// and the datapath it steers (slave).
interface control_sequencer_if;
    logic       MemReady;
    logic       ALUReg, ALUImmediate, Branch, JALR, JAL, AUIPC, LUI, Load, Store, System;
    logic       BranchTaken;
    logic       MemRead, MemWrite;
    logic       IRWrite, PCWrite, RegWrite;
    logic [1:0] PCSelect, WBSelect;
    logic       Halted, Fault;
    logic [2:0] State;

    modport master (
        input  MemReady, ALUReg, ALUImmediate, Branch, JALR, JAL, AUIPC, LUI,
               Load, Store, System, BranchTaken,
        output MemRead, MemWrite, IRWrite, PCWrite, RegWrite, PCSelect,
               WBSelect, Halted, Fault, State
    );

    modport slave (
        output MemReady, ALUReg, ALUImmediate, Branch, JALR, JAL, AUIPC, LUI,
               Load, Store, System, BranchTaken,
        input  MemRead, MemWrite, IRWrite, PCWrite, RegWrite, PCSelect,
               WBSelect, Halted, Fault, State
    );
endinterface

// File: rtl/control_sequencer_wait_timer.sv
// Memory wait counter: counts cycles without MemReady and flags the cycle
// whose wait would bring the count up to LIMIT.
module wait_timer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with memory-wait timeout and an absorbing HALT state.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    state_t  state;
    iclass_t cls;
    logic    load_q, store_q, branch_q, jal_q, jalr_q, lui_q, taken_q;
    logic    fault_q;
    logic    timer_clear, timer_enable, timer_expired;
    pcsel_t  pcsel;
    wbsel_t  wbsel;

    assign cls = '{
        alureg: bus.ALUReg,  aluimm: bus.ALUImmediate, branch: bus.Branch,
        jalr:   bus.JALR,    jal:    bus.JAL,          auipc:  bus.AUIPC,
        lui:    bus.LUI,     load:   bus.Load,         store:  bus.Store,
        system: bus.System
    };

    // Counter is held at zero outside the two request states, so it starts
    // from zero on every entry to FETCH or MEMORY.
    assign timer_clear  = !(state == FETCH || state == MEMORY);
    assign timer_enable = !timer_clear && !bus.MemReady;

    wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            branch_q <= 1'b0;
            jal_q    <= 1'b0;
            jalr_q   <= 1'b0;
            lui_q    <= 1'b0;
            taken_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.MemReady) begin
                        state <= DECODE;
                    end else if (timer_expired) begin
                        state   <= HALT;
                        fault_q <= 1'b1;
                    end
                end
                DECODE: state <= EXECUTE;
                EXECUTE: begin
                    load_q   <= cls.load;
                    store_q  <= cls.store;
                    branch_q <= cls.branch;
                    jal_q    <= cls.jal;
                    jalr_q   <= cls.jalr;
                    lui_q    <= cls.lui;
                    taken_q  <= bus.BranchTaken;
                    if (!is_onehot(cls)) begin
                        state   <= HALT;
                        fault_q <= 1'b1;
                    end else if (cls.system) begin
                        state <= HALT;
                    end else if (cls.load || cls.store) begin
                        state <= MEMORY;
                    end else begin
                        state <= WRITEBACK;
                    end
                end
                MEMORY: begin
                    if (bus.MemReady) begin
                        state <= WRITEBACK;
                    end else if (timer_expired) begin
                        state   <= HALT;
                        fault_q <= 1'b1;
                    end
                end
                WRITEBACK: state <= FETCH;
                HALT:      state <= HALT;
                default:   state <= HALT;
            endcase
        end
    end

    // Strobes decode the registered state; the reset term keeps the FETCH
    // request low while reset is held, so the first fetch starts right after.
    always_comb begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.Halted   = 1'b0;
        bus.Fault    = 1'b0;
        pcsel        = PC_PLUS4;
        wbsel        = WB_ALU;
        case (state)
            FETCH: begin
                bus.MemRead = !reset;
                bus.IRWrite = !reset && bus.MemReady;
            end
            MEMORY: begin
                bus.MemRead  = load_q;
                bus.MemWrite = store_q;
            end
            WRITEBACK: begin
                bus.PCWrite  = 1'b1;
                bus.RegWrite = !(branch_q || store_q);
                if (jal_q || (branch_q && taken_q)) begin
                    pcsel = PC_TARGET;
                end else if (jalr_q) begin
                    pcsel = PC_JALR;
                end
                if (load_q) begin
                    wbsel = WB_LOAD;
                end else if (jal_q || jalr_q) begin
                    wbsel = WB_PC4;
                end else if (lui_q) begin
                    wbsel = WB_UIMM;
                end
            end
            HALT: begin
                bus.Halted = 1'b1;
                bus.Fault  = fault_q;
            end
            default: ;
        endcase
    end

    assign bus.PCSelect = pcsel;
    assign bus.WBSelect = wbsel;
    assign bus.State    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe capture against
// hand-derived cycle patterns, with MEM_TIMEOUT overridden to 4.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [9:0] C_ALUREG = 10'b1000000000;
    localparam logic [9:0] C_ALUI   = 10'b0100000000;
    localparam logic [9:0] C_BRANCH = 10'b0010000000;
    localparam logic [9:0] C_JALR   = 10'b0001000000;
    localparam logic [9:0] C_JAL    = 10'b0000100000;
    localparam logic [9:0] C_AUIPC  = 10'b0000010000;
    localparam logic [9:0] C_LUI    = 10'b0000001000;
    localparam logic [9:0] C_LOAD   = 10'b0000000100;
    localparam logic [9:0] C_STORE  = 10'b0000000010;
    localparam logic [9:0] C_SYSTEM = 10'b0000000001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    control_sequencer_if bus();

    control_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] r_memread, r_memwrite, r_irwrite, r_pcwrite, r_regwrite, r_halted, r_fault;
    logic [1:0]  r_pcsel [16];
    logic [1:0]  r_wbsel [16];
    logic [2:0]  r_state [16];

    task automatic set_class(input logic [9:0] c, input logic taken);
        {bus.ALUReg, bus.ALUImmediate, bus.Branch, bus.JALR, bus.JAL, bus.AUIPC,
         bus.LUI, bus.Load, bus.Store, bus.System} = c;
        bus.BranchTaken = taken;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.MemReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Bit i of rdy is MemReady during the i-th captured cycle.
    task automatic run(input int n, input logic [15:0] rdy);
        r_memread = '0; r_memwrite = '0; r_irwrite = '0; r_pcwrite = '0;
        r_regwrite = '0; r_halted = '0; r_fault = '0;
        for (int i = 0; i < n; i++) begin
            bus.MemReady = rdy[i];
            #1;
            r_memread[i]  = bus.MemRead;
            r_memwrite[i] = bus.MemWrite;
            r_irwrite[i]  = bus.IRWrite;
            r_pcwrite[i]  = bus.PCWrite;
            r_regwrite[i] = bus.RegWrite;
            r_halted[i]   = bus.Halted;
            r_fault[i]    = bus.Fault;
            r_pcsel[i]    = bus.PCSelect;
            r_wbsel[i]    = bus.WBSelect;
            r_state[i]    = bus.State;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        set_class(C_ALUI, 1'b0);
        reset = 1'b1;
        bus.MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.State !== FETCH) begin n_bad++; $display("FAIL reset_state got %0d want %0d", bus.State, FETCH); end
        n_cmp++; if ({bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 00000", {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite}); end
        n_cmp++; if ({bus.Halted, bus.Fault} !== 2'b00) begin n_bad++; $display("FAIL reset_halt got %b want 00", {bus.Halted, bus.Fault}); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.MemRead, bus.IRWrite} !== 2'b11) begin n_bad++; $display("FAIL reset_first_fetch got %b want 11", {bus.MemRead, bus.IRWrite}); end
    endtask

    task automatic test_addi();
        do_reset();
        set_class(C_ALUI, 1'b0);
        run(5, 16'hFFFF);
        n_cmp++; if (r_irwrite[4:0] !== 5'b10001) begin n_bad++; $display("FAIL addi_irwrite got %b want 10001", r_irwrite[4:0]); end
        n_cmp++; if (r_memread[4:0] !== 5'b10001) begin n_bad++; $display("FAIL addi_memread got %b want 10001", r_memread[4:0]); end
        n_cmp++; if (r_pcwrite[4:0] !== 5'b01000) begin n_bad++; $display("FAIL addi_pcwrite got %b want 01000", r_pcwrite[4:0]); end
        n_cmp++; if (r_regwrite[4:0] !== 5'b01000) begin n_bad++; $display("FAIL addi_regwrite got %b want 01000", r_regwrite[4:0]); end
        n_cmp++; if ({r_pcsel[3], r_wbsel[3]} !== 4'b0000) begin n_bad++; $display("FAIL addi_sel got %b want 0000", {r_pcsel[3], r_wbsel[3]}); end
        n_cmp++; if ({r_state[1], r_state[2], r_state[3]} !== {DECODE, EXECUTE, WRITEBACK}) begin
            n_bad++; $display("FAIL addi_states got %h want %h", {r_state[1], r_state[2], r_state[3]}, {DECODE, EXECUTE, WRITEBACK}); end
    endtask

    task automatic test_load_wait();
        do_reset();
        set_class(C_LOAD, 1'b0);
        // ready in F, D, E; three waits in MEMORY then ready; WB; stalled F
        run(9, 16'h00C7);
        n_cmp++; if (r_memread[8:0] !== 9'h179) begin n_bad++; $display("FAIL load_memread got %h want 179", r_memread[8:0]); end
        n_cmp++; if (r_memwrite[8:0] !== 9'h000) begin n_bad++; $display("FAIL load_memwrite got %h want 000", r_memwrite[8:0]); end
        n_cmp++; if (r_irwrite[8:0] !== 9'h001) begin n_bad++; $display("FAIL load_irwrite got %h want 001", r_irwrite[8:0]); end
        n_cmp++; if (r_regwrite[8:0] !== 9'h080) begin n_bad++; $display("FAIL load_regwrite got %h want 080", r_regwrite[8:0]); end
        n_cmp++; if (r_wbsel[7] !== WB_LOAD) begin n_bad++; $display("FAIL load_wbsel got %0d want 1", r_wbsel[7]); end
        n_cmp++; if (r_halted[8:0] !== 9'h000) begin n_bad++; $display("FAIL load_no_timeout got %h want 000", r_halted[8:0]); end
    endtask

    task automatic test_branch_jalr();
        do_reset();
        set_class(C_BRANCH, 1'b1);
        run(3, 16'hFFFF);
        bus.BranchTaken = 1'b0;
        run(1, 16'hFFFF);
        n_cmp++; if ({r_pcwrite[0], r_regwrite[0], r_pcsel[0]} !== 4'b1001) begin
            n_bad++; $display("FAIL br_taken got %b want 1001", {r_pcwrite[0], r_regwrite[0], r_pcsel[0]}); end
        run(3, 16'hFFFF);
        bus.BranchTaken = 1'b1;
        run(1, 16'hFFFF);
        n_cmp++; if ({r_pcwrite[0], r_regwrite[0], r_pcsel[0]} !== 4'b1000) begin
            n_bad++; $display("FAIL br_not_taken got %b want 1000", {r_pcwrite[0], r_regwrite[0], r_pcsel[0]}); end
        set_class(C_JALR, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_regwrite[3], r_pcsel[3], r_wbsel[3]} !== 5'b11010) begin
            n_bad++; $display("FAIL jalr got %b want 11010", {r_regwrite[3], r_pcsel[3], r_wbsel[3]}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_class(C_JAL, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_regwrite[3], r_pcsel[3], r_wbsel[3]} !== 5'b10110) begin
            n_bad++; $display("FAIL jal got %b want 10110", {r_regwrite[3], r_pcsel[3], r_wbsel[3]}); end
        set_class(C_LUI, 1'b1);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_regwrite[3], r_pcsel[3], r_wbsel[3]} !== 5'b10011) begin
            n_bad++; $display("FAIL lui got %b want 10011", {r_regwrite[3], r_pcsel[3], r_wbsel[3]}); end
        set_class(C_STORE, 1'b0);
        run(5, 16'hFFFF);
        n_cmp++; if ({r_memwrite[4:0], r_memread[4:0]} !== 10'b01000_00001) begin
            n_bad++; $display("FAIL store_mem got %b want 0100000001", {r_memwrite[4:0], r_memread[4:0]}); end
        n_cmp++; if ({r_pcwrite[4:0], r_regwrite[4:0]} !== 10'b10000_00000) begin
            n_bad++; $display("FAIL store_wb got %b want 1000000000", {r_pcwrite[4:0], r_regwrite[4:0]}); end
        set_class(C_AUIPC, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_regwrite[3], r_pcsel[3], r_wbsel[3]} !== 5'b10000) begin
            n_bad++; $display("FAIL auipc got %b want 10000", {r_regwrite[3], r_pcsel[3], r_wbsel[3]}); end
        set_class(C_ALUREG, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_irwrite[3:0], r_regwrite[3:0]} !== 8'b0001_1000) begin
            n_bad++; $display("FAIL alureg got %b want 00011000", {r_irwrite[3:0], r_regwrite[3:0]}); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_class(C_ALUI, 1'b0);
        run(6, 16'h0000);
        n_cmp++; if (r_memread[5:0] !== 6'b001111) begin n_bad++; $display("FAIL to_memread got %b want 001111", r_memread[5:0]); end
        n_cmp++; if (r_halted[5:0] !== 6'b110000) begin n_bad++; $display("FAIL to_halted got %b want 110000", r_halted[5:0]); end
        n_cmp++; if (r_fault[5:0] !== 6'b110000) begin n_bad++; $display("FAIL to_fault got %b want 110000", r_fault[5:0]); end
        n_cmp++; if (r_state[4] !== HALT) begin n_bad++; $display("FAIL to_state got %0d want %0d", r_state[4], HALT); end
        run(3, 16'hFFFF);
        n_cmp++; if ((r_memread[2:0] | r_memwrite[2:0] | r_irwrite[2:0] | r_pcwrite[2:0] | r_regwrite[2:0]) !== 3'b000) begin
            n_bad++; $display("FAIL halt_strobes got %b want 000", r_memread[2:0] | r_memwrite[2:0] | r_irwrite[2:0] | r_pcwrite[2:0] | r_regwrite[2:0]); end
        n_cmp++; if ({r_halted[2:0], r_fault[2:0]} !== 6'b111111) begin
            n_bad++; $display("FAIL halt_absorb got %b want 111111", {r_halted[2:0], r_fault[2:0]}); end
    endtask

    task automatic test_system_fault();
        do_reset();
        set_class(C_SYSTEM, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_halted[3:0], r_fault[3:0]} !== 8'b1000_0000) begin
            n_bad++; $display("FAIL system got %b want 10000000", {r_halted[3:0], r_fault[3:0]}); end
        do_reset();
        set_class(C_BRANCH | C_LOAD, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_halted[3:0], r_fault[3:0], r_memread[3:0]} !== 12'b1000_1000_0001) begin
            n_bad++; $display("FAIL multi_class got %b want 100010000001", {r_halted[3:0], r_fault[3:0], r_memread[3:0]}); end
        do_reset();
        set_class(10'b0, 1'b0);
        run(4, 16'hFFFF);
        n_cmp++; if ({r_halted[3:0], r_fault[3:0]} !== 8'b1000_1000) begin
            n_bad++; $display("FAIL no_class got %b want 10001000", {r_halted[3:0], r_fault[3:0]}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_class(C_STORE, 1'b0);
        run(4, 16'h0007);
        n_cmp++; if ({r_memwrite[3:0], r_state[3]} !== {4'b1000, MEMORY}) begin
            n_bad++; $display("FAIL mid_store got %b want %b", {r_memwrite[3:0], r_state[3]}, {4'b1000, MEMORY}); end
        bus.MemReady = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if ({bus.MemWrite, bus.MemRead, bus.State} !== {2'b00, FETCH}) begin
            n_bad++; $display("FAIL mid_reset got %b want %b", {bus.MemWrite, bus.MemRead, bus.State}, {2'b00, FETCH}); end
        #2;
        reset = 1'b0;
        bus.MemReady = 1'b1;
        #1;
        n_cmp++; if ({bus.MemRead, bus.IRWrite} !== 2'b11) begin n_bad++; $display("FAIL mid_refetch got %b want 11", {bus.MemRead, bus.IRWrite}); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.State !== DECODE) begin n_bad++; $display("FAIL mid_decode got %0d want %0d", bus.State, DECODE); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_class(10'b0, 1'b0);
        bus.MemReady = 1'b0;
        test_reset();
        test_addi();
        test_load_wait();
        test_branch_jalr();
        test_back_to_back();
        test_timeout();
        test_system_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 255: maximum wait cycles for MemReady before fault (range 1..255).
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL provide port MemReady, input, 1: memory completes the current read/write in this cycle.
REQ-005 SHALL provide ports ALUReg, ALUImmediate, Branch, JALR, JAL, AUIPC, LUI, Load, Store, System, input, 1 each: one-hot instruction class from the decoder.
REQ-006 SHALL provide port BranchTaken, input, 1: branch comparison result, valid in EXECUTE.
REQ-007 SHALL provide ports MemRead and MemWrite, output, 1 each: memory request strobes.
REQ-008 SHALL provide port IRWrite, output, 1: instruction register load enable.
REQ-009 SHALL provide port PCWrite, output, 1: program counter update enable.
REQ-010 SHALL provide port PCSelect, output, 2: 0 = PC+4, 1 = PC+Bimm/Jimm, 2 = (rs1+Iimm)&~1.
REQ-011 SHALL provide port RegWrite, output, 1: register file write enable.
REQ-012 SHALL provide port WBSelect, output, 2: 0 = ALU, 1 = load data, 2 = PC+4, 3 = Uimm.
REQ-013 SHALL provide ports Halted and Fault, output, 1 each: sequencer stopped; stop caused by error.
REQ-014 SHALL provide port State, output, 3: current state encoding, for debug.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-016 In FETCH, SHALL assert MemRead; on MemReady, SHALL assert IRWrite for that cycle and go to DECODE.
REQ-017 DECODE SHALL last exactly one cycle with all strobes low; SHALL then go to EXECUTE.
REQ-018 In EXECUTE, SHALL go to HALT (Fault=0) on System, to HALT (Fault=1) if zero or more than one class flag is set, to MEMORY on Load/Store, and to WRITEBACK otherwise.
REQ-019 In MEMORY, SHALL hold MemRead (Load) or MemWrite (Store) high until MemReady, then go to WRITEBACK.
REQ-020 In WRITEBACK, SHALL assert PCWrite for one cycle and assert RegWrite for every class except Branch and Store; SHALL then go to FETCH.
REQ-021 PCSelect in WRITEBACK SHALL be 1 for JAL or for Branch with BranchTaken registered in EXECUTE, 2 for JALR, and 0 otherwise.
REQ-022 WBSelect SHALL be 1 for Load, 2 for JAL/JALR, 3 for LUI, and 0 for ALUReg/ALUImmediate/AUIPC.
REQ-023 MemRead and MemWrite SHALL never be high in the same cycle; IRWrite, PCWrite, and RegWrite SHALL be single-cycle pulses per instruction.
REQ-024 SHALL use an 8-bit wait counter, cleared on entry to FETCH or MEMORY and incremented each cycle MemReady is low; when it reaches MEM_TIMEOUT, SHALL go to HALT with Fault=1 and drop all strobes.
REQ-025 MemReady asserted in the first request cycle SHALL complete with zero wait; MemReady outside FETCH or MEMORY SHALL be ignored.
REQ-026 Latency without memory waits SHALL be 4 cycles for ALU/branch/jump/LUI/AUIPC and 5 cycles for Load/Store.
REQ-027 HALT SHALL be absorbing until reset, with Halted=1 and all strobes low.

Reset
REQ-028 reset SHALL immediately force FETCH, counter 0, Halted=0, Fault=0, and all strobes 0, including mid-transaction; the first fetch SHALL begin in the first cycle after deassertion.

Structure
REQ-029 State encodings and the PCSelect and WBSelect codes SHALL be defined in a shared package used by the datapath and bench.
REQ-030 The wait counter SHALL be a sub-module, wait_timer, with clear, enable, and expired signals.

Verification
REQ-031 ADDI with MemReady tied high -> IRWrite in cycle 1; RegWrite=1, WBSelect=0, PCWrite=1, PCSelect=0 in cycle 4.
REQ-032 Load with MemReady delayed 3 cycles in MEMORY -> MemRead held 4 cycles; RegWrite with WBSelect=1 occurs once.
REQ-033 Branch with BranchTaken=1 and then 0 -> PCSelect=1 and then 0; RegWrite=0 both times; JALR -> PCSelect=2, WBSelect=2.
REQ-034 MemReady held low with MEM_TIMEOUT=4 -> HALT with Fault=1 after 4 wait cycles, and strobes low from then on.
REQ-035 System -> Halted=1, Fault=0; Branch and Load both set -> Fault=1.
REQ-036 reset asserted mid-MEMORY with Store -> MemWrite drops in the same cycle; FETCH restarts after deassertion.
